cardinal_nic: RTL

- Network interface controller between one processor and one gold_router endpoint of the cardinal bidirectional ring.
- Presents a 4-register memory-mapped interface to the processor.
- Holds one 1-entry output channel buffer (processor to ring) and one 1-entry input channel buffer (ring to processor).
- On the router side, drives pesi/pedi and consumes peri; consumes peso/pedo and drives pero. Injection is gated by the ring clock polarity.

---
 rtl/nic_pkg.sv | 13 +
 rtl/nic_channel_buf.sv | 27 ++
 rtl/cardinal_nic.sv | 84 ++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// Shared constants for the cardinal ring network interface controller:
// register map, status-bit position and the packet VC/polarity bit.
package nic_pkg;
  localparam int PAC_SIZE_DEFAULT = 64;

  localparam logic [1:0] ADDR_ICB_DATA = 2'b00;
  localparam logic [1:0] ADDR_ICB_STAT = 2'b01;
  localparam logic [1:0] ADDR_OCB_DATA = 2'b10;
  localparam logic [1:0] ADDR_OCB_STAT = 2'b11;

  localparam int STAT_FULL_BIT = 0;
  localparam int VC_BIT        = PAC_SIZE_DEFAULT - 1;
endpackage

// File: rtl/nic_channel_buf.sv
// One-entry channel buffer. A load always wins over a clear.
// The data register keeps its last value after a clear.
module nic_channel_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         full,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// Network interface between a processor and one gold_router endpoint:
// four memory-mapped registers, a 1-entry output and a 1-entry input buffer.
module cardinal_nic
  import nic_pkg::*;
#(
  parameter int PAC_SIZE = 64,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [PAC_SIZE-1:0] d_in,
  output logic [PAC_SIZE-1:0] d_out,
  input  logic                nicEn,
  input  logic                nicWrEn,
  output logic                net_so,
  input  logic                net_ro,
  output logic [PAC_SIZE-1:0] net_do,
  input  logic                net_si,
  output logic                net_ri,
  input  logic [PAC_SIZE-1:0] net_di,
  input  logic                net_polarity
);

  localparam int VC = PAC_SIZE - 1;

  logic                ocb_full, icb_full;
  logic [PAC_SIZE-1:0] ocb_data, icb_data;
  logic                ocb_load, icb_load, icb_clear;
  logic                proc_wr, proc_rd;
  logic [PAC_SIZE-1:0] icb_stat, ocb_stat;

  assign proc_wr = nicEn & nicWrEn;
  assign proc_rd = nicEn & ~nicWrEn;

  // A write landing while the buffer is full (even if it drains this cycle) is dropped.
  assign ocb_load  = proc_wr & (addr == ADDR_W'(ADDR_OCB_DATA)) & ~ocb_full;
  assign net_so    = ocb_full & net_ro & (ocb_data[VC] == net_polarity);
  assign net_do    = ocb_data;

  assign net_ri    = ~icb_full;
  assign icb_load  = net_si & ~icb_full;
  assign icb_clear = proc_rd & (addr == ADDR_W'(ADDR_ICB_DATA)) & icb_full;

  nic_channel_buf #(.W(PAC_SIZE)) ocb (
    .clk       (clk),
    .reset     (reset),
    .load      (ocb_load),
    .clear     (net_so),
    .load_data (d_in),
    .full      (ocb_full),
    .data      (ocb_data)
  );

  nic_channel_buf #(.W(PAC_SIZE)) icb (
    .clk       (clk),
    .reset     (reset),
    .load      (icb_load),
    .clear     (icb_clear),
    .load_data (net_di),
    .full      (icb_full),
    .data      (icb_data)
  );

  always_comb begin
    icb_stat = '0;
    ocb_stat = '0;
    icb_stat[STAT_FULL_BIT] = icb_full;
    ocb_stat[STAT_FULL_BIT] = ocb_full;
  end

  always_comb begin
    d_out = '0;
    if (proc_rd) begin
      case (addr)
        ADDR_W'(ADDR_ICB_DATA): d_out = icb_data;
        ADDR_W'(ADDR_ICB_STAT): d_out = icb_stat;
        ADDR_W'(ADDR_OCB_DATA): d_out = ocb_data;
        default:                d_out = ocb_stat;
      endcase
    end
  end

endmodule
